// File: rtl/usb_tx_pkg.sv
// Shared definitions for the USB transmit path: packet command encoding,
// scheduler state encoding and the width of the scheduler timer.
package usb_tx_pkg;

  localparam logic [1:0] PKT_IDLE = 2'b00;
  localparam logic [1:0] PKT_DATA = 2'b01;
  localparam logic [1:0] PKT_ACK  = 2'b10;
  localparam logic [1:0] PKT_NAK  = 2'b11;

  localparam int TIMER_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } sched_state_t;

endpackage

// File: rtl/tx_sched_timer.sv
// Loadable up-counter with clear and a terminal-count flag; one instance is
// time-shared between the SEND timeout and the inter-packet gap.
module tx_sched_timer
  import usb_tx_pkg::*;
(
  input  logic               clk,
  input  logic               n_rst,
  input  logic               clear,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_value,
  input  logic               en,
  input  logic [TIMER_W-1:0] terminal,
  output logic               tc
);

  logic [TIMER_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == terminal);

endmodule

// File: rtl/usb_tx_scheduler.sv
// Schedules ACK/NAK handshakes and DATA packets to the USB transmitter with
// handshake priority, a fixed inter-packet gap and a SEND timeout.
module usb_tx_scheduler
  import usb_tx_pkg::*;
#(
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       ack_req,
  input  logic       nak_req,
  input  logic       data_req,
  input  logic [6:0] data_size,
  input  logic       tx_done,
  output logic [1:0] tx_packet,
  output logic [6:0] tx_packet_data_size,
  output logic       hs_sent,
  output logic       data_sent,
  output logic       tx_error,
  output logic       busy
);

  localparam logic [TIMER_W-1:0] SEND_TERM = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] GAP_TERM  =
    (GAP_CYCLES > 0) ? TIMER_W'(GAP_CYCLES - 1) : '0;

  sched_state_t       state;
  sched_state_t       state_next;
  logic               hs_pend;
  logic [1:0]         hs_type;
  logic               data_pend;
  logic [6:0]         pend_size;
  logic               serve_done;
  logic               serve_abort;
  logic               serve_end;
  logic               serving_hs;
  logic               timer_clear;
  logic               timer_en;
  logic [TIMER_W-1:0] timer_term;
  logic               timer_tc;

  // ACK and NAK both have the MSB set, so it identifies a handshake in flight.
  assign serving_hs = tx_packet[1];
  assign serve_end  = serve_done | serve_abort;

  always_comb begin
    state_next  = state;
    serve_done  = 1'b0;
    serve_abort = 1'b0;
    case (state)
      ST_IDLE: begin
        if (hs_pend || data_pend) state_next = ST_SEND;
      end
      ST_SEND: begin
        if (tx_done) serve_done = 1'b1;
        else if (timer_tc) serve_abort = 1'b1;
        if (tx_done || timer_tc) state_next = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
      end
      ST_GAP: begin
        if (timer_tc) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // The timer restarts from zero on every state change so each phase counts from 0.
  assign timer_clear = (state_next != state) || (state == ST_IDLE);
  assign timer_en    = (state != ST_IDLE);
  assign timer_term  = (state == ST_GAP) ? GAP_TERM : SEND_TERM;

  tx_sched_timer u_timer (
    .clk        (clk),
    .n_rst      (n_rst),
    .clear      (timer_clear),
    .load       (1'b0),
    .load_value ('0),
    .en         (timer_en),
    .terminal   (timer_term),
    .tc         (timer_tc)
  );

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state               <= ST_IDLE;
      hs_pend             <= 1'b0;
      hs_type             <= PKT_IDLE;
      data_pend           <= 1'b0;
      pend_size           <= '0;
      tx_packet           <= PKT_IDLE;
      tx_packet_data_size <= '0;
      hs_sent             <= 1'b0;
      data_sent           <= 1'b0;
      tx_error            <= 1'b0;
      busy                <= 1'b0;
    end else begin
      state     <= state_next;
      busy      <= (state_next != ST_IDLE);
      hs_sent   <= serve_done & serving_hs;
      data_sent <= serve_done & ~serving_hs;
      tx_error  <= serve_abort;

      // A new request in the same cycle its pending bit is retired re-arms it.
      hs_pend   <= (hs_pend & ~(serve_end & serving_hs)) | ack_req | nak_req;
      if (ack_req || nak_req) hs_type <= nak_req ? PKT_NAK : PKT_ACK;

      data_pend <= (data_pend & ~(serve_end & ~serving_hs)) | data_req;
      if (data_req && (!data_pend || (serve_end && !serving_hs))) pend_size <= data_size;

      if (state == ST_IDLE) begin
        if (hs_pend) begin
          tx_packet <= hs_type;
        end else if (data_pend) begin
          tx_packet           <= PKT_DATA;
          tx_packet_data_size <= pend_size;
        end
      end else if (serve_end) begin
        tx_packet <= PKT_IDLE;
      end
    end
  end

endmodule
